// File: rtl/nios_hs_pkg.sv
// Shared definitions for the Nios ack/data PIO to stream bridge: FSM states, defaults, log2 helper.
package nios_hs_pkg;

   localparam int DEFAULT_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_ARM   = 2'd0,
      ST_IDLE  = 2'd1,
      ST_STALL = 2'd2,
      ST_ACKED = 2'd3
   } hs_state_e;

   // Ceiling log2; log2_ceil(1) is 0.
   function automatic int log2_ceil(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/nios_ack_stream_bridge_if.sv
// Bundle of the Nios PIO handshake/status signals and the outgoing word stream.
interface nios_ack_stream_bridge_if
   import nios_hs_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int DEPTH  = 4
);
   localparam int LVL_W = log2_ceil(DEPTH) + 1;

   logic              ack_in;
   logic [DATA_W-1:0] data_in;
   logic              done_out;
   logic              full_out;
   logic              overflow_out;
   logic              clr_overflow;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic [LVL_W-1:0]  fill_level;

   // The bridge itself.
   modport slave (
      input  ack_in, data_in, clr_overflow, out_ready,
      output done_out, full_out, overflow_out, out_data, out_valid, fill_level
   );

   // The Nios software side together with the stream consumer.
   modport master (
      output ack_in, data_in, clr_overflow, out_ready,
      input  done_out, full_out, overflow_out, out_data, out_valid, fill_level
   );

endinterface

// File: rtl/hs_fifo.sv
// First-word fall-through FIFO; head_data is valid whenever empty is low.
module hs_fifo
   import nios_hs_pkg::*;
#(
   parameter int  DATA_W = DEFAULT_DATA_W,
   parameter int  DEPTH  = 4,
   localparam int PTR_W  = log2_ceil(DEPTH),
   localparam int LVL_W  = PTR_W + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic              empty,
   output logic              full,
   output logic [LVL_W-1:0]  level
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  level_q;
   logic              do_push;
   logic              do_pop;

   assign empty   = (level_q == '0);
   assign full    = (level_q == LVL_W'(DEPTH));
   assign level   = level_q;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // NOTE: the storage array has no reset (it would cost a reset net per bit for nothing);
   // stale contents are hidden by forcing head_data to zero while empty.
   assign head_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         // DEPTH is a power of two, so the pointers wrap on natural overflow.
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/nios_ack_stream_bridge.sv
// Turns the Nios four-phase ack/done PIO handshake into a buffered valid/ready word stream.
module nios_ack_stream_bridge
   import nios_hs_pkg::*;
#(
   parameter int DATA_W      = DEFAULT_DATA_W,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   nios_ack_stream_bridge_if.slave bus
);

   localparam int LVL_W = log2_ceil(DEPTH) + 1;

   logic              ack_s;
   logic              primed;
   hs_state_e         state_q;
   hs_state_e         state_d;
   logic              capture;
   logic              ovf_set;
   logic              wr_pending;
   logic [DATA_W-1:0] wr_data;
   logic              done_q;
   logic              overflow_q;
   logic              fifo_empty;
   logic              fifo_full;
   logic [DATA_W-1:0] fifo_head;
   logic [LVL_W-1:0]  fifo_level;

   // ack_s only becomes trustworthy once the reset zeros have drained out of the
   // synchroniser; until then ARM must not mistake them for a low ack.
   generate
      if (SYNC_STAGES == 0) begin : g_direct
         assign ack_s  = bus.ack_in;
         assign primed = 1'b1;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;
         logic [1:0]             prime_q;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               sync_q  <= '0;
               prime_q <= '0;
            end else begin
               sync_q[0] <= bus.ack_in;
               for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
               if (!primed) prime_q <= prime_q + 2'd1;
            end
         end

         assign ack_s  = sync_q[SYNC_STAGES-1];
         assign primed = (prime_q == 2'(SYNC_STAGES));
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_ARM;
      else       state_q <= state_d;
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      ovf_set = 1'b0;
      unique case (state_q)
         ST_ARM:   if (primed && !ack_s) state_d = ST_IDLE;
         ST_IDLE: begin
            if (ack_s) begin
               if (!fifo_full) begin
                  capture = 1'b1;
                  state_d = ST_ACKED;
               end else begin
                  state_d = ST_STALL;
               end
            end
         end
         ST_STALL: begin
            if (!ack_s) begin
               ovf_set = 1'b1;
               state_d = ST_IDLE;
            end else if (!fifo_full) begin
               capture = 1'b1;
               state_d = ST_ACKED;
            end
         end
         ST_ACKED: if (!ack_s) state_d = ST_IDLE;
         default:  state_d = ST_ARM;
      endcase
   end

   // The captured word is written one edge after capture, so it becomes visible on
   // the stream on the same edge that done_out rises.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_pending <= 1'b0;
         wr_data    <= '0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_pending <= capture;
         if (capture) wr_data <= bus.data_in;
         done_q <= (state_q == ST_ACKED);
         if (ovf_set)               overflow_q <= 1'b1;
         else if (bus.clr_overflow) overflow_q <= 1'b0;
      end
   end

   hs_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (wr_pending),
      .push_data (wr_data),
      .pop       (!fifo_empty && bus.out_ready),
      .head_data (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .level     (fifo_level)
   );

   assign bus.done_out     = done_q;
   assign bus.full_out     = fifo_full;
   assign bus.overflow_out = overflow_q;
   assign bus.out_data     = fifo_head;
   assign bus.out_valid    = !fifo_empty;
   assign bus.fill_level   = fifo_level;

endmodule

// File: tb/tb_nios_ack_stream_bridge.sv
// Self-checking bench: directed table/sequence tests plus a randomized run against a queue model.
module tb_nios_ack_stream_bridge;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam int SYNC   = 2;

   typedef struct {
      logic [31:0] data;
      logic [31:0] exp_level;
      logic        exp_full;
   } fill_vec_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   logic        dir_ready   = 1'b0;
   logic        rnd_ready   = 1'b0;
   bit          mon_en      = 1'b0;
   bit          pop_pending = 1'b0;
   bit          done_prev   = 1'b0;
   logic [31:0] model_q[$];
   logic [31:0] head;
   logic [31:0] lvl;
   fill_vec_t   fill_tbl[4];

   always #5 clk = ~clk;

   nios_ack_stream_bridge_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   nios_ack_stream_bridge #(
      .DATA_W      (DATA_W),
      .DEPTH       (DEPTH),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.out_ready = mon_en ? rnd_ready : dir_ready;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Bounded wait for done_out to reach a level; an expired budget shows up as a failed check.
   task automatic wait_done(input logic level, input int budget, input string name);
      for (int i = 0; i < budget && bus.done_out !== level; i++) @(negedge clk);
      check(name, bus.done_out, level);
   endtask

   // One software handshake: write data, raise ack, wait done, hold, drop ack, wait done low.
   task automatic handshake(input logic [31:0] d, input int hold,
                            output logic [31:0] head_o, output logic [31:0] lvl_o);
      bus.data_in = d;
      bus.ack_in  = 1'b1;
      wait_done(1'b1, 200, "done_rise");
      head_o = bus.out_data;
      lvl_o  = bus.fill_level;
      tick(hold);
      bus.ack_in = 1'b0;
      wait_done(1'b0, 200, "done_fall");
   endtask

   task automatic drain_expect(input logic [31:0] d);
      check("drain_valid", bus.out_valid, 1);
      check("drain_data", bus.out_data, d);
      dir_ready = 1'b1;
      tick(1);
      dir_ready = 1'b0;
   endtask

   // Reference model for the random run: every acknowledged handshake appends its word,
   // every accepted stream beat removes the oldest one.
   always @(negedge clk) begin
      if (mon_en) begin
         if (pop_pending) void'(model_q.pop_front());
         if (bus.done_out && !done_prev) model_q.push_back(bus.data_in);
         done_prev = bus.done_out;
         check("rnd_level", bus.fill_level, model_q.size());
         check("rnd_valid", bus.out_valid, model_q.size() > 0);
         check("rnd_full", bus.full_out, model_q.size() == DEPTH);
         check("rnd_overflow", bus.overflow_out, 0);
         if (model_q.size() > 0) check("rnd_data", bus.out_data, model_q[0]);
         rnd_ready   = ($urandom_range(0, 2) != 0);
         pop_pending = (model_q.size() > 0) && rnd_ready;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.ack_in       = 1'b1;
      bus.data_in      = '0;
      bus.clr_overflow = 1'b0;

      // Reset with ack left high: nothing may be captured after release.
      tick(2);
      check("rst_valid", bus.out_valid, 0);
      check("rst_data", bus.out_data, 0);
      check("rst_done", bus.done_out, 0);
      check("rst_full", bus.full_out, 0);
      check("rst_overflow", bus.overflow_out, 0);
      check("rst_level", bus.fill_level, 0);
      reset = 1'b0;
      tick(6);
      check("arm_valid", bus.out_valid, 0);
      check("arm_done", bus.done_out, 0);
      check("arm_level", bus.fill_level, 0);
      bus.ack_in = 1'b0;
      tick(4);
      bus.data_in = 32'hDEADBEEF;
      bus.ack_in  = 1'b1;
      tick(SYNC + 1);
      check("lat_valid_early", bus.out_valid, 0);
      check("lat_done_early", bus.done_out, 0);
      tick(1);
      check("lat_valid", bus.out_valid, 1);
      check("lat_data", bus.out_data, 32'hDEADBEEF);
      check("lat_done", bus.done_out, 1);
      bus.ack_in = 1'b0;
      wait_done(1'b0, 20, "lat_done_fall");
      drain_expect(32'hDEADBEEF);
      check("lat_empty", bus.fill_level, 0);

      // Back-to-back handshakes with a always-ready consumer.
      dir_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         handshake(32'(i), 0, head, lvl);
         check("b2b_head", head, 32'(i));
         check("b2b_level", lvl, 1);
         check("b2b_level_after", bus.fill_level, 0);
      end
      dir_ready = 1'b0;

      // Ack held high for ten cycles still yields exactly one word.
      handshake(32'h4, 10, head, lvl);
      check("hold_level", bus.fill_level, 1);
      drain_expect(32'h4);
      check("hold_empty", bus.fill_level, 0);

      // Fill to full from a table of handshakes.
      fill_tbl[0] = '{32'h11, 32'd1, 1'b0};
      fill_tbl[1] = '{32'h12, 32'd2, 1'b0};
      fill_tbl[2] = '{32'h13, 32'd3, 1'b0};
      fill_tbl[3] = '{32'h14, 32'd4, 1'b1};
      for (int i = 0; i < 4; i++) begin
         handshake(fill_tbl[i].data, 0, head, lvl);
         check("fill_level", lvl, fill_tbl[i].exp_level);
         check("fill_full", bus.full_out, fill_tbl[i].exp_full);
         check("fill_head", head, 32'h11);
      end

      // Fifth handshake stalls until one pop frees a slot.
      bus.data_in = 32'h15;
      bus.ack_in  = 1'b1;
      tick(8);
      check("stall_done", bus.done_out, 0);
      check("stall_level", bus.fill_level, 4);
      dir_ready = 1'b1;
      tick(1);
      dir_ready = 1'b0;
      check("stall_pop_full", bus.full_out, 0);
      check("stall_pop_level", bus.fill_level, 3);
      check("stall_pop_head", bus.out_data, 32'h12);
      tick(1);
      check("stall_capture_level", bus.fill_level, 3);
      check("stall_capture_done", bus.done_out, 0);
      tick(1);
      check("stall_push_level", bus.fill_level, 4);
      check("stall_push_full", bus.full_out, 1);
      check("stall_push_done", bus.done_out, 1);
      bus.ack_in = 1'b0;
      wait_done(1'b0, 20, "stall_done_fall");
      for (int i = 2; i <= 5; i++) drain_expect(32'h10 + 32'(i));
      dir_ready = 1'b1;
      tick(3);
      dir_ready = 1'b0;
      check("idle_ready_level", bus.fill_level, 0);
      check("idle_ready_valid", bus.out_valid, 0);

      // Abandoned request while stalled sets the sticky overflow flag.
      for (int i = 1; i <= 4; i++) handshake(32'h20 + 32'(i), 0, head, lvl);
      bus.data_in = 32'h25;
      bus.ack_in  = 1'b1;
      tick(6);
      check("ovf_stall_done", bus.done_out, 0);
      bus.ack_in = 1'b0;
      tick(4);
      check("ovf_set", bus.overflow_out, 1);
      check("ovf_no_push", bus.fill_level, 4);
      check("ovf_done", bus.done_out, 0);
      tick(3);
      check("ovf_sticky", bus.overflow_out, 1);
      bus.clr_overflow = 1'b1;
      tick(1);
      bus.clr_overflow = 1'b0;
      check("ovf_clear", bus.overflow_out, 0);
      bus.ack_in = 1'b1;
      tick(6);
      bus.ack_in = 1'b0;
      tick(SYNC);
      bus.clr_overflow = 1'b1;
      tick(1);
      bus.clr_overflow = 1'b0;
      check("ovf_set_wins", bus.overflow_out, 1);
      bus.clr_overflow = 1'b1;
      tick(1);
      bus.clr_overflow = 1'b0;
      check("ovf_clear2", bus.overflow_out, 0);
      check("ovf_level", bus.fill_level, 4);

      // Simultaneous push and pop at level 2.
      drain_expect(32'h21);
      drain_expect(32'h22);
      bus.data_in = 32'h26;
      bus.ack_in  = 1'b1;
      tick(SYNC + 1);
      check("pp_pre_level", bus.fill_level, 2);
      check("pp_pre_done", bus.done_out, 0);
      dir_ready = 1'b1;
      tick(1);
      dir_ready = 1'b0;
      check("pp_level", bus.fill_level, 2);
      check("pp_head", bus.out_data, 32'h24);
      check("pp_done", bus.done_out, 1);
      bus.ack_in = 1'b0;
      wait_done(1'b0, 20, "pp_done_fall");
      drain_expect(32'h24);
      drain_expect(32'h26);

      // Eight pushes in two fill/drain rounds exercise pointer wrap.
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) handshake(32'h100 + 32'(r * 4 + i), 0, head, lvl);
         check("wrap_full", bus.full_out, 1);
         for (int i = 0; i < 4; i++) drain_expect(32'h100 + 32'(r * 4 + i));
      end

      // Reset in ACKED with three words queued.
      handshake(32'h31, 0, head, lvl);
      handshake(32'h32, 0, head, lvl);
      bus.data_in = 32'h33;
      bus.ack_in  = 1'b1;
      wait_done(1'b1, 20, "mr_acked");
      check("mr_level", bus.fill_level, 3);
      reset = 1'b1;
      #1;
      check("mr_valid", bus.out_valid, 0);
      check("mr_data", bus.out_data, 0);
      check("mr_done", bus.done_out, 0);
      check("mr_level0", bus.fill_level, 0);
      check("mr_full", bus.full_out, 0);
      check("mr_overflow", bus.overflow_out, 0);
      tick(2);
      reset = 1'b0;
      tick(6);
      check("mr_arm_level", bus.fill_level, 0);
      check("mr_arm_done", bus.done_out, 0);
      bus.ack_in = 1'b0;
      tick(4);
      handshake(32'h34, 0, head, lvl);
      check("mr_new_head", head, 32'h34);
      check("mr_new_level", lvl, 1);
      drain_expect(32'h34);

      // Randomized handshakes against the queue model with a random consumer.
      done_prev = bus.done_out;
      mon_en    = 1'b1;
      for (int n = 0; n < 40; n++) begin
         handshake($urandom, $urandom_range(0, 4), head, lvl);
         tick($urandom_range(0, 3));
      end
      tick(2);
      mon_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nios_ack_stream_bridge.md
Name: nios_ack_stream_bridge

Overview:
- Downstream consumer of the Nios "ack" PIO output bit, paired with a companion 32-bit data PIO.
- Converts the software-driven four-phase handshake (Nios writes data, raises ack, waits for done, drops ack) into a buffered valid/ready word stream toward the hardware side.
- Returns done/full/overflow status bits that are wired back into Nios input PIOs.

Parameters:
- DATA_W, 32, width of captured data word and output stream.
- DEPTH, 4, FIFO entries; power of two, 2..16.
- SYNC_STAGES, 2, synchroniser flops on ack_in; legal 0..3, where 0 is a direct same-clock connection.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ack_in  in  1  level from the ack PIO out_port.
- data_in  in  DATA_W  word from the data PIO; software holds it stable while ack_in is high.
- done_out  out  1  handshake acknowledge to Nios.
- full_out  out  1  FIFO full.
- overflow_out  out  1  sticky; set when a request is abandoned while stalled.
- clr_overflow  in  1  single-cycle clear pulse for overflow_out.
- out_data  out  DATA_W  head-of-FIFO word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the word.
- fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset state: all outputs 0, FIFO empty, synchroniser flops 0, FSM in ARM.
- ack_s is ack_in delayed by SYNC_STAGES flops. data_in is sampled unsynchronised, only at the push edge.
- FSM states: ARM, IDLE, STALL, ACKED.
  - ARM: go to IDLE when ack_s==0. This prevents capturing an ack left high across reset.
  - IDLE: if ack_s==1 and !full, push data_in and go to ACKED. If ack_s==1 and full, go to STALL.
  - STALL: if ack_s==0, set overflow, no push, go to IDLE. Else if !full, push data_in and go to ACKED.
  - ACKED: when ack_s==0, go to IDLE.
- done_out is registered and equals (state==ACKED). It rises one cycle after the push edge and falls one cycle after ack_s is seen low.
- One push per ack high phase. A second push needs ack_in to fall and then rise again.
- Latency:
  - ack_in rises before edge 0 → push at edge SYNC_STAGES.
  - out_valid and done_out go high after edge SYNC_STAGES+1.
- FIFO is first-word fall-through:
  - out_data is valid whenever out_valid is high.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop leaves fill_level unchanged.
  - Read and write pointers wrap modulo DEPTH. fill_level ranges 0..DEPTH.
- The FSM uses registered full_out, so a push never occurs when full.
  - If a pop occurs while full and the FSM is in STALL, full_out falls on the next edge and the push happens on the following edge.
- overflow_out:
  - Set has priority over a coincident clr_overflow.
  - Otherwise clr_overflow clears it on the next edge.
  - Only reset clears it without a clear pulse.
- Reset asserted mid-handshake: state, FIFO contents and overflow are discarded at once (asynchronous). After release the FSM stays in ARM until ack_s reads 0.
- out_ready while out_valid==0 has no effect.

Decomposition:
- Shared package nios_hs_pkg holds:
  - FSM state encodings: ST_ARM=2'd0, ST_IDLE=2'd1, ST_STALL=2'd2, ST_ACKED=2'd3.
  - Default DATA_W.
  - A log2 helper function.
- One sub-module: hs_fifo.
  - Parameterised DATA_W and DEPTH; first-word fall-through.
  - Ports: push, push_data, pop, head_data, empty, full, level.
- The top level contains the synchroniser, FSM, overflow flag and output registers.

Test Plan:
- Reset release with ack_in=1, SYNC_STAGES=2: FSM holds in ARM, no push, done_out=0. Drop ack_in, then raise it with data_in=32'hDEADBEEF: out_valid=1 and out_data=DEADBEEF three edges after the rise; done_out=1 on the same edge.
- Back-to-back handshakes with out_ready=1 and data 1,2,3: stream emits 1,2,3 in order. done_out toggles once per handshake, fill_level never exceeds 1, and holding ack_in high for 10 cycles yields exactly one push.
- out_ready=0, five handshakes, DEPTH=4: first four complete with fill_level 1..4 and full_out=1. Fifth handshake stalls with done_out=0. Pulse out_ready for one cycle: word 1 pops, full_out falls, push of word 5 two edges later, done_out=1.
- In STALL (FIFO full), drop ack_in: overflow_out=1, no push, fill_level stays 4. Pulse clr_overflow: overflow_out=0 next edge. Coincident set and clear: overflow_out=1.
- Simultaneous push and pop at fill_level=2: level stays 2 and head order is preserved. Write-pointer wrap after eight pushes with DEPTH=4 returns correct data.
- Assert reset while in ACKED with fill_level=3: all outputs 0 immediately. After release, ack_in still high → no capture until ack_in goes low and high again.
